idct_shift_pipe: RTL and testbench

IDCT_SHIFT_PIPE -- requirements
Module: idct_shift_pipe

---
 rtl/idct_shift_pipe.sv | 142 ++++++++++++++
 tb/tb_idct_shift_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_shift_pipe.sv
// Shift unit for the IDCT datapath: arithmetic/logical/rounding right shifts and
// saturating left shift, followed by a STAGES-deep elastic pipeline carrying a tag.
module idct_shift_pipe #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 6,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_sat
);

  localparam logic [1:0] MODE_ASR = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_RND = 2'b10;
  localparam logic [1:0] MODE_SHL = 2'b11;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("idct_shift_pipe: STAGES must be in 1..4");
  end
  if (DATA_W < 8 || DATA_W > 64) begin : g_bad_width
    $error("idct_shift_pipe: DATA_W must be in 8..64");
  end
  if (SHAMT_W < $clog2(DATA_W) || SHAMT_W > 32) begin : g_bad_shamt
    $error("idct_shift_pipe: SHAMT_W too narrow for DATA_W");
  end

  function automatic logic signed [DATA_W-1:0] asr_f(
    input logic signed [DATA_W-1:0] x,
    input logic [SHAMT_W-1:0]       shamt
  );
    int unsigned sh;
    sh = 32'(shamt);
    if (sh >= DATA_W) return {DATA_W{x[DATA_W-1]}};
    return x >>> sh;
  endfunction

  function automatic logic signed [DATA_W-1:0] lsr_f(
    input logic signed [DATA_W-1:0] x,
    input logic [SHAMT_W-1:0]       shamt
  );
    int unsigned sh;
    sh = 32'(shamt);
    if (sh >= DATA_W) return '0;
    return $signed($unsigned(x) >> sh);
  endfunction

  // Round-half-up: add back the last bit shifted out. Cannot overflow for shamt >= 1.
  function automatic logic signed [DATA_W-1:0] round_f(
    input logic signed [DATA_W-1:0] x,
    input logic [SHAMT_W-1:0]       shamt
  );
    int unsigned sh;
    sh = 32'(shamt);
    if (sh == 0 || sh >= DATA_W) return asr_f(x, shamt);
    return asr_f(x, shamt) + $signed({{(DATA_W-1){1'b0}}, x[sh-1]});
  endfunction

  // A left shift is lossless iff shifting back arithmetically restores the operand.
  function automatic logic signed [DATA_W-1:0] sat_shl_f(
    input  logic signed [DATA_W-1:0] x,
    input  logic [SHAMT_W-1:0]       shamt,
    output logic                     sat
  );
    int unsigned sh;
    logic signed [DATA_W-1:0] shl;
    sh  = 32'(shamt);
    sat = 1'b0;
    if (sh == 0 || x == '0) return x;
    if (sh < DATA_W) begin
      shl = x <<< sh;
      if ((shl >>> sh) == x) return shl;
    end
    sat = 1'b1;
    return x[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  logic signed [DATA_W-1:0] res_c;
  logic                     sat_c;
  logic                     en;

  logic        [STAGES-1:0] vld_p;
  logic signed [DATA_W-1:0] data_p [STAGES];
  logic        [TAG_W-1:0]  tag_p  [STAGES];
  logic                     sat_p  [STAGES];

  always_comb begin
    sat_c = 1'b0;
    res_c = '0;
    case (in_mode)
      MODE_ASR: res_c = asr_f($signed(in_data), in_shamt);
      MODE_LSR: res_c = lsr_f($signed(in_data), in_shamt);
      MODE_RND: res_c = round_f($signed(in_data), in_shamt);
      MODE_SHL: res_c = sat_shl_f($signed(in_data), in_shamt, sat_c);
      default:  res_c = '0;
    endcase
  end

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Stage boundary: all stages advance together on en; valid bits keep bubbles in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_p[0] <= res_c;
      tag_p[0]  <= in_tag;
      sat_p[0]  <= sat_c;
      for (int i = 1; i < STAGES; i++) begin
        data_p[i] <= data_p[i-1];
        tag_p[i]  <= tag_p[i-1];
        sat_p[i]  <= sat_p[i-1];
      end
    end
  end

  // Output boundary: payload is masked by valid so reset presents zeros.
  assign out_valid = vld_p[STAGES-1];
  assign out_data  = out_valid ? data_p[STAGES-1] : '0;
  assign out_tag   = out_valid ? tag_p[STAGES-1]  : '0;
  assign out_sat   = out_valid && sat_p[STAGES-1];

endmodule

// File: tb/tb_idct_shift_pipe.sv
// Randomized bench for idct_shift_pipe: scoreboard fed by an arithmetic reference
// model, plus directed vectors, stall/stream handshake and mid-flight reset.
module tb_idct_shift_pipe;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 6;
  localparam int STAGES  = 2;
  localparam int TAG_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               out_sat;

  always #5 clk = ~clk;

  idct_shift_pipe #(
    .DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .STAGES(STAGES), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_sat(out_sat)
  );

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              sat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   n_out  = 0;

  logic              stall_prev = 1'b0;
  logic [DATA_W-1:0] hold_data;
  logic [TAG_W-1:0]  hold_tag;
  logic              hold_sat;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic longint floordiv(input longint a, input longint p);
    longint q;
    q = a / p;
    if ((a % p) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: results as integer arithmetic on the operand's numeric value.
  function automatic exp_t model(input logic [1:0] m, input logic [DATA_W-1:0] d,
                                 input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t);
    exp_t   e;
    longint v, u, p, r, prod;
    longint max_pos, min_neg;
    int     si;
    max_pos = 64'sd2147483647;
    min_neg = -64'sd2147483648;
    v  = longint'($signed(d));
    u  = longint'(d);
    si = int'(s);
    p  = longint'(1) << si;
    e.tag = t;
    e.sat = 1'b0;
    r = 0;
    case (m)
      2'b00: r = (si >= DATA_W) ? ((v < 0) ? -1 : 0) : floordiv(v, p);
      2'b01: r = (si >= DATA_W) ? 0 : u / p;
      2'b10: begin
        if (si == 0) r = v;
        else if (si >= DATA_W) r = (v < 0) ? -1 : 0;
        else r = floordiv(v + p / 2, p);
      end
      default: begin
        prod = (si < DATA_W) ? v * p : 0;
        if (si == 0 || v == 0) r = v;
        else if (si < DATA_W && prod >= min_neg && prod <= max_pos) r = prod;
        else begin
          e.sat = 1'b1;
          r = (v < 0) ? min_neg : max_pos;
        end
      end
    endcase
    e.data = r[DATA_W-1:0];
    return e;
  endfunction

  // One clock: drive after the rising edge, observe at the falling edge.
  task automatic step(input logic iv, input logic [1:0] m, input logic [DATA_W-1:0] d,
                      input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t,
                      input logic ordy, output logic accepted);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = iv; in_mode = m; in_data = d; in_shamt = s; in_tag = t; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, hold_data);
      chk("stall_tag", out_tag, hold_tag);
      chk("stall_sat", out_sat, hold_sat);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        n_out++;
        chk("out_data", out_data, e.data);
        chk("out_tag", out_tag, e.tag);
        chk("out_sat", out_sat, e.sat);
      end
    end
    accepted = iv && in_ready;
    if (accepted) sb.push_back(model(m, d, s, t));
    stall_prev = out_valid && !out_ready;
    hold_data = out_data; hold_tag = out_tag; hold_sat = out_sat;
  endtask

  task automatic directed(input string name, input logic [1:0] m, input logic [DATA_W-1:0] d,
                          input logic [SHAMT_W-1:0] s, input logic [TAG_W-1:0] t,
                          input logic [DATA_W-1:0] exp_d, input logic exp_s);
    logic acc;
    int   lat;
    logic [DATA_W-1:0] got_d;
    logic [TAG_W-1:0]  got_t;
    logic              got_s;
    lat = 0; got_d = '0; got_t = '0; got_s = 1'b0;
    step(1'b1, m, d, s, t, 1'b1, acc);
    chk({name, "_accept"}, acc, 1);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
      if (out_valid) begin
        lat = k; got_d = out_data; got_t = out_tag; got_s = out_sat;
      end
    end
    chk({name, "_latency"}, lat, STAGES);
    chk({name, "_data"}, got_d, exp_d);
    chk({name, "_tag"}, got_t, t);
    chk({name, "_sat"}, got_s, exp_s);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 2 * STAGES + 2; k++) step(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic have;
    logic [1:0]         m;
    logic [DATA_W-1:0]  d;
    logic [SHAMT_W-1:0] s;
    logic [TAG_W-1:0]   t;
    logic [SHAMT_W-1:0] shamts [6];
    logic [DATA_W-1:0]  specials [5];
    int   got, out_base;

    shamts   = '{6'd0, 6'd1, 6'd31, 6'd32, 6'd40, 6'd63};
    specials = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    directed("asr_neg", 2'b00, 32'h8000_0010, 6'd4, 6'd5, 32'hF800_0001, 1'b0);
    directed("lsr_31", 2'b01, 32'h8000_0000, 6'd31, 6'd6, 32'h0000_0001, 1'b0);
    directed("lsr_40", 2'b01, 32'h8000_0000, 6'd40, 6'd7, 32'h0000_0000, 1'b0);
    directed("asr_40", 2'b00, 32'h8000_0000, 6'd40, 6'd8, 32'hFFFF_FFFF, 1'b0);
    directed("rnd_m5", 2'b10, 32'hFFFF_FFFB, 6'd1, 6'd9, 32'hFFFF_FFFE, 1'b0);
    directed("rnd_7s1", 2'b10, 32'd7, 6'd1, 6'd10, 32'd4, 1'b0);
    directed("rnd_7s0", 2'b10, 32'd7, 6'd0, 6'd11, 32'd7, 1'b0);
    directed("shl_ok", 2'b11, 32'h2000_0000, 6'd1, 6'd12, 32'h4000_0000, 1'b0);
    directed("shl_satp", 2'b11, 32'h2000_0000, 6'd2, 6'd13, 32'h7FFF_FFFF, 1'b1);
    directed("shl_satn", 2'b11, 32'hC000_0000, 6'd2, 6'd14, 32'h8000_0000, 1'b1);
    directed("shl_zero", 2'b11, 32'h0, 6'd63, 6'd15, 32'h0, 1'b0);

    // Eight back-to-back operands against a 1,0,0,1 ready pattern.
    out_base = n_out; got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      step(1'b1, 2'(got % 4), 32'h1234_5678 + 32'(got * 32'h1111), 6'(got + 3), 6'(40 + got),
           (c % 4 == 0) || (c % 4 == 3), acc);
      if (acc) got++;
    end
    chk("stream_accepted", got, 8);
    drain();
    chk("stream_outputs", n_out - out_base, 8);

    // Randomized traffic with operands held until accepted.
    have = 1'b0; m = '0; d = '0; s = '0; t = '0;
    for (int c = 0; c < 500; c++) begin
      if (!have && $urandom_range(3) != 0) begin
        have = 1'b1;
        m = 2'($urandom_range(3));
        s = ($urandom_range(2) == 0) ? shamts[$urandom_range(5)] : 6'($urandom_range(63));
        case ($urandom_range(3))
          0:       d = specials[$urandom_range(4)];
          1:       d = $urandom >> $urandom_range(31);
          default: d = $urandom;
        endcase
        t = 6'($urandom_range(63));
      end
      step(have, m, d, s, t, $urandom_range(9) < 6, acc);
      if (acc) have = 1'b0;
    end
    drain();

    // Reset with two operands in flight.
    step(1'b1, 2'b00, 32'h100, 6'd1, 6'd1, 1'b0, acc);
    step(1'b1, 2'b00, 32'h200, 6'd1, 6'd2, 1'b0, acc);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
      chk("post_rst_idle", out_valid, 0);
    end
    directed("post_rst", 2'b01, 32'hF000_0000, 6'd4, 6'd33, 32'h0F00_0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
